// File: rtl/mf_selftest_ctrl.sv
// rtl/mf_selftest_ctrl.sv - matched-filter self-test sequencer: passthrough, zero flush, impulse, response check
module mf_selftest_ctrl #(
    parameter int NBITS        = 12,
    parameter int NSAMPS       = 8,
    parameter int LATENCY      = 10,
    parameter int FLUSH_CYCLES = 8,
    parameter int CAP_CYCLES   = 8,
    parameter int EXP_SUM      = 0,
    parameter int EXP_ABSSUM   = 48,
    parameter int ACCW         = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NBITS*NSAMPS-1:0]       adc_i,
    input  logic                          start_i,
    input  logic [NBITS-1:0]              amp_i,
    output logic [NBITS*NSAMPS-1:0]       mf_data_o,
    input  logic [(NBITS+6)*NSAMPS-1:0]   mf_data_i,
    output logic                          valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic [ACCW-1:0]               sum_o,
    output logic [ACCW-1:0]               abssum_o
);
    localparam int OUTW      = NBITS + 6;
    localparam int WARM_LOAD = LATENCY + FLUSH_CYCLES;
    localparam int CNTW      = $clog2(WARM_LOAD + 1);
    localparam logic signed [ACCW-1:0] EXP_SUM_W    = ACCW'(EXP_SUM);
    localparam logic signed [ACCW-1:0] EXP_ABSSUM_W = ACCW'(EXP_ABSSUM);

    typedef enum logic [2:0] {
        ST_WARMUP, ST_RUN, ST_FLUSH, ST_IMPULSE, ST_WAIT, ST_CAPTURE, ST_CHECK
    } state_t;

    state_t                    state_q, state_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [NBITS-1:0]          amp_q, amp_d;
    logic signed [ACCW-1:0]    sum_q, sum_d, abssum_q, abssum_d;
    logic                      pass_q, pass_d;
    logic [NBITS*NSAMPS-1:0]   mf_data_q, mf_data_d;

    logic signed [ACCW-1:0]    samp, step_sum, step_abs;
    logic signed [ACCW-1:0]    amp_ext, amp_abs, exp_sum, exp_abs;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_WARMUP;
            cnt_q     <= CNTW'(WARM_LOAD);
            amp_q     <= '0;
            sum_q     <= '0;
            abssum_q  <= '0;
            pass_q    <= 1'b0;
            mf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            amp_q     <= amp_d;
            sum_q     <= sum_d;
            abssum_q  <= abssum_d;
            pass_q    <= pass_d;
            mf_data_q <= mf_data_d;
        end
    end

    // Counter is loaded with (clocks in state - 1) on entry; leave the state when it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
        end
        case (state_q)
            ST_WARMUP:  if (cnt_q == '0) state_d = ST_RUN;
            ST_RUN: begin
                if (start_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNTW'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH:   if (cnt_q == '0) state_d = ST_IMPULSE;
            ST_IMPULSE: begin
                state_d = ST_WAIT;
                cnt_d   = CNTW'(LATENCY - 2);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = CNTW'(CAP_CYCLES - 1);
                end
            end
            ST_CAPTURE: if (cnt_q == '0) state_d = ST_CHECK;
            ST_CHECK: begin
                state_d = ST_WARMUP;
                cnt_d   = CNTW'(WARM_LOAD);
            end
            default: begin
                state_d = ST_WARMUP;
                cnt_d   = CNTW'(WARM_LOAD);
            end
        endcase
    end

    // Decoded from the next state so the impulse sits on mf_data_o during the IMPULSE clock itself.
    always_comb begin
        mf_data_d = '0;
        case (state_d)
            ST_WARMUP, ST_RUN: mf_data_d = adc_i;
            ST_IMPULSE:        mf_data_d[NBITS-1:0] = amp_q;
            default:           mf_data_d = '0;
        endcase
        valid_o = (state_q == ST_RUN);
        busy_o  = (state_q != ST_WARMUP) && (state_q != ST_RUN);
        done_o  = (state_q == ST_CHECK);
    end

    always_comb begin
        step_sum = '0;
        step_abs = '0;
        samp     = '0;
        for (int k = 0; k < NSAMPS; k++) begin
            samp     = {{(ACCW-OUTW){mf_data_i[k*OUTW+OUTW-1]}}, mf_data_i[k*OUTW +: OUTW]};
            step_sum = step_sum + samp;
            step_abs = step_abs + (samp[ACCW-1] ? -samp : samp);
        end
    end

    always_comb begin
        amp_ext = {{(ACCW-NBITS){amp_q[NBITS-1]}}, amp_q};
        amp_abs = amp_q[NBITS-1] ? -amp_ext : amp_ext;
        exp_sum = EXP_SUM_W * amp_ext;
        exp_abs = EXP_ABSSUM_W * amp_abs;
    end

    // The verdict is registered on the last capture clock so pass_o is valid alongside done_o.
    always_comb begin
        amp_d    = amp_q;
        sum_d    = sum_q;
        abssum_d = abssum_q;
        pass_d   = pass_q;
        case (state_q)
            ST_RUN: begin
                if (start_i) begin
                    amp_d    = amp_i;
                    sum_d    = '0;
                    abssum_d = '0;
                    pass_d   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                sum_d    = sum_q + step_sum;
                abssum_d = abssum_q + step_abs;
                if (cnt_q == '0) begin
                    pass_d = (sum_d == exp_sum) && (abssum_d == exp_abs);
                end
            end
            default: ;
        endcase
    end

    assign mf_data_o = mf_data_q;
    assign pass_o    = pass_q;
    assign sum_o     = sum_q;
    assign abssum_o  = abssum_q;

endmodule

// File: tb/tb_mf_selftest_ctrl.sv
// tb/tb_mf_selftest_ctrl.sv - directed bench for mf_selftest_ctrl with a 14-tap filter model
module tb_mf_selftest_ctrl;
    localparam int NBITS        = 12;
    localparam int NSAMPS       = 8;
    localparam int LATENCY      = 10;
    localparam int FLUSH_CYCLES = 8;
    localparam int CAP_CYCLES   = 8;
    localparam int ACCW         = 32;
    localparam int OUTW         = NBITS + 6;
    localparam int NTAPS        = 14;
    localparam int CW           = NBITS * NSAMPS;
    localparam int WARM_CLKS    = LATENCY + FLUSH_CYCLES + 1;
    localparam int BUSY_CLKS    = FLUSH_CYCLES + LATENCY + CAP_CYCLES + 1;

    logic                  aclk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [CW-1:0]         adc_i = '0;
    logic                  start_i = 1'b0;
    logic [NBITS-1:0]      amp_i = '0;
    logic [CW-1:0]         mf_data_o;
    logic [OUTW*NSAMPS-1:0] mf_data_i;
    logic                  valid_o, busy_o, done_o, pass_o;
    logic [ACCW-1:0]       sum_o, abssum_o;

    mf_selftest_ctrl #(
        .NBITS(NBITS), .NSAMPS(NSAMPS), .LATENCY(LATENCY), .FLUSH_CYCLES(FLUSH_CYCLES),
        .CAP_CYCLES(CAP_CYCLES), .EXP_SUM(0), .EXP_ABSSUM(48), .ACCW(ACCW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .adc_i(adc_i), .start_i(start_i), .amp_i(amp_i),
        .mf_data_o(mf_data_o), .mf_data_i(mf_data_i), .valid_o(valid_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .sum_o(sum_o), .abssum_o(abssum_o)
    );

    always #5 aclk = ~aclk;

    // Filter taps: sum 0, sum of magnitudes 48.
    int taps [NTAPS] = '{1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 3, -3};
    int xh [NTAPS];
    logic [OUTW*NSAMPS-1:0] pipe [LATENCY+1];
    bit inject_armed = 1'b0;
    int done_cnt = 0;

    always @(negedge aclk) begin
        logic [OUTW*NSAMPS-1:0] yv;
        int acc;
        int xs;
        yv = '0;
        for (int k = 0; k < NSAMPS; k++) begin
            xs = int'($signed(mf_data_o[k*NBITS +: NBITS]));
            for (int j = NTAPS-1; j > 0; j--) xh[j] = xh[j-1];
            xh[0] = xs;
            acc = 0;
            for (int j = 0; j < NTAPS; j++) acc += taps[j] * xh[j];
            if (k == 0 && inject_armed && busy_o && xs != 0) begin
                acc += 1;
                inject_armed = 1'b0;
            end
            yv[k*OUTW +: OUTW] = acc[OUTW-1:0];
        end
        for (int j = LATENCY; j > 0; j--) pipe[j] = pipe[j-1];
        pipe[0] = yv;
        mf_data_i = pipe[LATENCY];
        if (done_o) done_cnt++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic run_test(input logic [NBITS-1:0] amp, input bit glitch,
                            output int nb, output int nv, output int nd,
                            output logic [ACCW-1:0] s, output logic [ACCW-1:0] a, output logic p);
        int d0;
        d0 = done_cnt;
        amp_i = amp;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        nb = 0; s = '0; a = '0; p = 1'b0;
        while (busy_o && nb < 200) begin
            if (done_o) begin
                s = sum_o; a = abssum_o; p = pass_o;
            end
            if (glitch && nb == 3) begin
                start_i = 1'b1;
                amp_i = 12'd7;
            end else begin
                start_i = 1'b0;
            end
            nb++;
            tick(1);
        end
        nv = 0;
        while (!valid_o && nv < 200) begin
            start_i = (glitch && nv == 5);
            nv++;
            tick(1);
        end
        start_i = 1'b0;
        nd = done_cnt - d0;
    endtask

    typedef struct {
        logic [NBITS-1:0] amp;
        bit               inject;
        bit               glitch;
        logic [ACCW-1:0]  exp_sum;
        logic [ACCW-1:0]  exp_abs;
        logic             exp_pass;
        string            name;
    } vec_t;

    vec_t vecs [5] = '{
        '{12'd100,  1'b0, 1'b0, 32'd0, 32'd4800,  1'b1, "amp100"},
        '{12'h800,  1'b0, 1'b0, 32'd0, 32'd98304, 1'b1, "ampneg2048"},
        '{12'd0,    1'b0, 1'b0, 32'd0, 32'd0,     1'b1, "amp0"},
        '{12'd100,  1'b1, 1'b0, 32'd1, 32'd4801,  1'b0, "inject"},
        '{12'd100,  1'b0, 1'b1, 32'd0, 32'd4800,  1'b1, "glitch"}
    };

    localparam logic [CW-1:0] P0 = 96'h0AB_0CD_0EF_012_034_056_078_09A;
    localparam logic [CW-1:0] P1 = 96'h123_456_789_ABC_DEF_010_7FF_800;
    localparam logic [CW-1:0] P2 = 96'hFFF_001_800_7FF_555_AAA_0F0_F0F;
    localparam logic [CW-1:0] P3 = 96'h321_654_987_CBA_FED_101_202_303;

    initial begin
        int n, nb, nv, nd, d0;
        logic [ACCW-1:0] s, a;
        logic p;

        adc_i = P0;
        aresetn = 1'b0;
        tick(2);
        check_eq("rst_mf_data", mf_data_o, CW'(0));
        check_eq("rst_valid", CW'(valid_o), CW'(0));
        check_eq("rst_busy", CW'(busy_o), CW'(0));
        check_eq("rst_done", CW'(done_o), CW'(0));
        check_eq("rst_pass", CW'(pass_o), CW'(0));
        check_eq("rst_sum", CW'(sum_o), CW'(0));
        check_eq("rst_abssum", CW'(abssum_o), CW'(0));

        aresetn = 1'b1;
        n = 0;
        while (!valid_o && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("warmup_clks", CW'(n), CW'(WARM_CLKS));
        adc_i = P1;
        tick(1);
        check_eq("pass_p1", mf_data_o, P1);
        adc_i = P2;
        #2;
        check_eq("pass_hold_p1", mf_data_o, P1);
        tick(1);
        check_eq("pass_p2", mf_data_o, P2);

        foreach (vecs[i]) begin
            inject_armed = vecs[i].inject;
            run_test(vecs[i].amp, vecs[i].glitch, nb, nv, nd, s, a, p);
            check_eq({vecs[i].name, "_busy_clks"}, CW'(nb), CW'(BUSY_CLKS));
            check_eq({vecs[i].name, "_done_cnt"}, CW'(nd), CW'(1));
            check_eq({vecs[i].name, "_sum"}, CW'(s), CW'(vecs[i].exp_sum));
            check_eq({vecs[i].name, "_abssum"}, CW'(a), CW'(vecs[i].exp_abs));
            check_eq({vecs[i].name, "_pass"}, CW'(p), CW'(vecs[i].exp_pass));
            check_eq({vecs[i].name, "_rewarm_clks"}, CW'(nv), CW'(WARM_CLKS));
            check_eq({vecs[i].name, "_sum_held"}, CW'(sum_o), CW'(vecs[i].exp_sum));
            check_eq({vecs[i].name, "_pass_held"}, CW'(pass_o), CW'(vecs[i].exp_pass));
        end
        tick(3);
        check_eq("glitch_no_restart", CW'(busy_o), CW'(0));

        d0 = done_cnt;
        amp_i = 12'd100;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(21);
        check_eq("midcap_busy", CW'(busy_o), CW'(1));
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        adc_i = P3;
        check_eq("midrst_busy", CW'(busy_o), CW'(0));
        check_eq("midrst_valid", CW'(valid_o), CW'(0));
        check_eq("midrst_sum", CW'(sum_o), CW'(0));
        check_eq("midrst_abssum", CW'(abssum_o), CW'(0));
        check_eq("midrst_pass", CW'(pass_o), CW'(0));
        tick(1);
        check_eq("midrst_passthru", mf_data_o, P3);
        n = 1;
        while (!valid_o && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("midrst_warmup_clks", CW'(n), CW'(WARM_CLKS));
        check_eq("midrst_no_done", CW'(done_cnt - d0), CW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
